clk_div_scheduler: RTL
======================

# clk_div_scheduler

Time-shares one 32-bit programmable clock divider among several requesters, each needing a different output frequency. Requesters assert a request with a divide count. The block grants them round-robin, loads the winner's count into the divider, and holds the grant for a programmed number of divider output toggles or until the request drops. It then resets the divider and moves on. It sits between the tone/rate-generation clients and the divider instance, and owns the divider's count input and reset.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `CNT_W`, default 32: divide-count width; matches the divider's count input.
- `HOLD_W`, default 16: width of the hold-toggle counter.

- `inclk`  in  1: system clock. The divider runs on the same clock.
- `Reset`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: per-requester request level.
- `req_count`  in  N_REQ*CNT_W: requester i's divide count in bits [i*CNT_W +: CNT_W].
- `hold_toggles`  in  HOLD_W: toggles to hold each grant. 0 means hold until `req` drops.
- `div_outclk`  in  1: divider output, a register in the `inclk` domain.
- `div_clk_count`  out  CNT_W: count driven to the divider.
- `div_reset`  out  1: registered reset to the divider.
- `grant`  out  N_REQ: one-hot current owner, or 0.
- `grant_done`  out  1: one-cycle pulse when a grant ends.
- `busy`  out  1: high in LOAD and RUN.

## Operation
- Reset values:
  - state IDLE; `div_reset`=1; `div_clk_count`=0; `grant`=0; `grant_done`=0; `busy`=0.
  - RR pointer `last`=N_REQ-1, so requester 0 wins first.
  - toggle counter 0; `prev_outclk` 0.
- IDLE:
  - `div_reset`=1.
  - If any `req` is high, pick the first requester in order `last`+1 … `last` (wrapping) whose `req` is high.
  - Register `grant`, the winner's count into `div_clk_count`, and `hold_toggles` into `hold_lat`.
  - Go to LOAD.
- Count clamp: a latched count of 0 is replaced by 1, because the divider never matches 0.
- LOAD: one cycle.
  - `div_reset` stays 1, so the divider loads with its counter cleared.
  - `prev_outclk`←0 and toggle counter←0.
  - Go to RUN. `div_reset` registers 0 on entry.
- RUN:
  - Toggle = `div_outclk` ≠ `prev_outclk`. `prev_outclk` updates every cycle, and each toggle increments the counter.
  - Go to RELEASE when either holds:
    - the granted requester's `req` is low;
    - `hold_lat` ≠ 0 and the counter reaches `hold_lat`, i.e. the toggle that makes it equal.
  - The `req`-drop exit has priority; both exits lead to the same result.
- RELEASE: one cycle.
  - `div_reset`←1, `grant`←0, `grant_done`=1, `last`←granted index.
  - Go to IDLE.
- `req_count` and `hold_toggles` changes during a grant are ignored; only the latched values are used.
- `Reset` in any state returns to reset values on the next edge and suppresses `grant_done`.
- Counter width is HOLD_W. It cannot wrap while `hold_lat` ≠ 0. When `hold_lat`=0 it saturates at all-ones.

## Timing
- A `req` rising at edge 0 in IDLE gives `grant` and `busy` at edge 1 (LOAD). `div_reset` falls at edge 2 (RUN).
- The divider's first toggle comes C edges after `div_reset` falls (C = latched count). It is detected one edge later.
- With hold H and count C, the RUN→RELEASE edge is about H·C+1 cycles after RUN entry. `grant_done` is high for the one RELEASE cycle.
- Minimum grant-to-grant turnaround: RELEASE, IDLE, LOAD gives 3 cycles of `div_reset`=1 between owners.
- A `req` that drops in LOAD is honoured at the first RUN cycle.

## Structure
- Package `clk_sched_pkg` holds:
  - the state enum {IDLE, LOAD, RUN, RELEASE};
  - localparams for the default widths;
  - a function that clamps a count of 0 to 1.
- One sub-module, `rr_arbiter`, is combinational. It takes `req`, `last`, `N_REQ` and returns a one-hot winner and its index.
- The top level contains the FSM, latches, edge detector and toggle counter.

## Test plan
- Single requester:
  - Stimulus: req0=1, count 4, hold 2.
  - Response: grant=0001 at edge 1, `div_reset` 0 from edge 2, two toggles about 4 cycles apart, `grant_done` pulse, `div_reset` back to 1.
- Round robin:
  - Stimulus: req0, req2 and req3 held high, hold 1.
  - Response: grant order 0001, 0100, 1000, 0001, each separated by 3 reset cycles.
- Request drop:
  - Stimulus: req1, count 10, hold 0; drop req1 in cycle 25.
  - Response: RELEASE next edge, `grant_done`=1, grant=0.
- Count 0:
  - Stimulus: req2 with count 0, hold 4.
  - Response: `div_clk_count`=1, toggle every cycle, release after 4 toggles.
- Reset mid-RUN:
  - Stimulus: assert `Reset` during RUN.
  - Response: next edge shows grant=0, `div_reset`=1, no `grant_done`, and requester 0 has priority afterwards.
- Mid-grant input changes:
  - Stimulus: change `req_count`/`hold_toggles` during RUN.
  - Response: `div_clk_count` is unchanged and the grant length follows the latched hold.

Source files
------------

// File: rtl/clk_sched_pkg.sv
// Shared types, default widths and helpers for the clock-divider scheduler.
package clk_sched_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_HOLD_W = 16;

  // Widest divide count the clamp helper handles; callers zero-extend into it.
  localparam int MAX_CNT_W  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } sched_state_t;

  // The divider never matches a count of 0, so 0 is promoted to 1.
  function automatic logic [MAX_CNT_W-1:0] clamp_count(input logic [MAX_CNT_W-1:0] count);
    return (count == '0) ? MAX_CNT_W'(1) : count;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after `last`, wrapping.
module rr_arbiter
  import clk_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  logic [IDX_W-1:0] cand;

  // Scan last+1 .. last (wrapping) and keep the first active request.
  always_comb begin
    win       = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
    if (win_valid) begin
      win[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_scheduler.sv
// Time-shares one programmable clock divider among N_REQ requesters.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | divider held in reset, waiting for any request
//   LOAD    | winner's count driven, divider still in reset for one cycle
//   RUN     | divider free-running, counting output toggles
//   RELEASE | grant_done pulse, divider back in reset, pointer advanced
module clk_div_scheduler
  import clk_sched_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic                   inclk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_count,
  input  logic [HOLD_W-1:0]      hold_toggles,
  input  logic                   div_outclk,
  output logic [CNT_W-1:0]       div_clk_count,
  output logic                   div_reset,
  output logic [N_REQ-1:0]       grant,
  output logic                   grant_done,
  output logic                   busy
);

  localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  sched_state_t     state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] gnt_idx;
  logic [HOLD_W-1:0] hold_lat;
  logic [HOLD_W-1:0] tog_cnt;
  logic             prev_outclk;

  logic [N_REQ-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [CNT_W-1:0] cnt_arr [N_REQ];
  logic [CNT_W-1:0] win_count;
  logic [CNT_W-1:0] win_count_clamped;

  logic             toggle;
  logic             owner_req;
  logic [HOLD_W-1:0] tog_cnt_inc;
  logic             hold_hit;
  logic             tog_cnt_full;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req),
    .last      (last),
    .win       (win),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign cnt_arr[g] = req_count[g*CNT_W +: CNT_W];
  end

  assign win_count         = cnt_arr[win_idx];
  assign win_count_clamped = CNT_W'(clamp_count(MAX_CNT_W'(win_count)));

  // Divider output is already registered in this domain, so one flop is
  // enough to detect its edges.
  assign toggle       = div_outclk ^ prev_outclk;
  assign owner_req    = req[gnt_idx];
  assign tog_cnt_inc  = tog_cnt + HOLD_W'(1);
  assign tog_cnt_full = &tog_cnt;
  assign hold_hit     = (hold_lat != '0) && toggle && (tog_cnt_inc == hold_lat);

  // Scheduler FSM with registered outputs, latched grant parameters and toggle counter.
  always_ff @(posedge inclk) begin
    if (Reset) begin
      state         <= IDLE;
      div_reset     <= 1'b1;
      div_clk_count <= '0;
      grant         <= '0;
      grant_done    <= 1'b0;
      busy          <= 1'b0;
      last          <= LAST_RST;
      gnt_idx       <= '0;
      hold_lat      <= '0;
      tog_cnt       <= '0;
      prev_outclk   <= 1'b0;
    end else begin
      grant_done <= 1'b0;
      case (state)
        IDLE: begin
          div_reset <= 1'b1;
          if (win_valid) begin
            grant         <= win;
            gnt_idx       <= win_idx;
            div_clk_count <= win_count_clamped;
            hold_lat      <= hold_toggles;
            busy          <= 1'b1;
            state         <= LOAD;
          end
        end

        LOAD: begin
          // Divider sees its new count while still cleared; release it next.
          prev_outclk <= 1'b0;
          tog_cnt     <= '0;
          div_reset   <= 1'b0;
          state       <= RUN;
        end

        RUN: begin
          prev_outclk <= div_outclk;
          // Saturation only matters in hold-until-drop mode; otherwise the
          // hold compare ends the grant before the counter can wrap.
          if (toggle && !tog_cnt_full) begin
            tog_cnt <= tog_cnt_inc;
          end
          if (!owner_req || hold_hit) begin
            div_reset  <= 1'b1;
            grant      <= '0;
            grant_done <= 1'b1;
            busy       <= 1'b0;
            last       <= gnt_idx;
            state      <= RELEASE;
          end
        end

        RELEASE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
